// File: rtl/cr_prefix_fe_seq_cmp.sv
// cr_prefix_fe_seq_cmp -- multi-lane masked sequence comparator for the
// prefix feature extractor. Each beat it checks up to N_LANES window ends
// against a per-record pattern of up to PAT_LEN masked byte compares. It keeps
// history across beats, so a match can span a beat boundary.
//
// Build option: define CR_PREFIX_FE_SEQ_CMP_CNT_EN to build the saturating
// per-record hit counter. When it is undefined, hit_cnt is tied to zero.
module cr_prefix_fe_seq_cmp #(
    parameter int N_LANES = 4,
    parameter int PAT_LEN = 8,
    parameter int OFF_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_LANES-1:0]   char_in,
    input  logic [N_LANES-1:0]     lane_vld,
    input  logic                   char_valid,
    input  logic                   char_last,
    input  logic [8*PAT_LEN-1:0]   match_val,
    input  logic [8*PAT_LEN-1:0]   match_mask,
    input  logic [2*PAT_LEN-1:0]   cmp_type,
    input  logic [4:0]             pat_len,
    input  logic                   anchor,
    output logic [N_LANES-1:0]     hit_vec,
    output logic                   first_hit_vld,
    output logic [OFF_W-1:0]       first_hit_off,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic                   rec_done
);

    localparam int HIST_N = PAT_LEN - 1;          // bytes of history kept
    localparam int SEQ_N  = HIST_N + N_LANES;     // history + current beat
    localparam int OW     = OFF_W + 9;            // headroom for offset sums

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FOUND = 2'd2;

    localparam logic [OFF_W-1:0] OFF_MAX = '1;

    logic [1:0]               state_q;
    logic [HIST_N-1:0][7:0]   hist_q;       // index 0 is the oldest byte
    logic [OFF_W-1:0]         off_q;        // record offset of the next byte
    logic [8*PAT_LEN-1:0]     cfg_val_q;
    logic [8*PAT_LEN-1:0]     cfg_mask_q;
    logic [2*PAT_LEN-1:0]     cfg_type_q;
    logic [4:0]               cfg_len_q;
    logic                     cfg_anchor_q;

    logic                     first_beat;
    logic [8*PAT_LEN-1:0]     val_eff;
    logic [8*PAT_LEN-1:0]     mask_eff;
    logic [2*PAT_LEN-1:0]     type_eff;
    logic [4:0]               len_eff;
    logic                     anchor_eff;
    logic [SEQ_N-1:0][7:0]    seq;
    logic [OW-1:0]            off_base;
    logic [N_LANES-1:0]       hits;
    logic [OFF_W-1:0]         first_off;
    logic [OFF_W-1:0]         off_next;
    logic [HIST_N-1:0][7:0]   hist_next;
    logic                     found_before;
    int                       k;
    int                       n_vld;

    // Masked unsigned compare of one character against one pattern byte.
    function automatic logic byte_cmp(input logic [7:0] c, input logic [7:0] v,
                                      input logic [7:0] m, input logic [1:0] op);
        logic [7:0] a;
        logic [7:0] b;
        a = c & m;
        b = v & m;
        case (op)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return a > b;
            default: return a < b;
        endcase
    endfunction

    // Clamp a wide offset sum to the counter range.
    function automatic logic [OFF_W-1:0] sat_off(input logic [OW-1:0] x);
        return (x > OW'(OFF_MAX)) ? OFF_MAX : x[OFF_W-1:0];
    endfunction

    // A record opens on any valid beat seen while idle. That beat starts with
    // empty history and offset 0, and uses the live configuration.
    assign first_beat   = (state_q == ST_IDLE);
    assign off_base     = first_beat ? '0 : OW'(off_q);
    assign found_before = !first_beat && (state_q == ST_FOUND);
    assign n_vld        = $countones(lane_vld);
    assign off_next     = sat_off(off_base + OW'(n_vld));

    // Select live config on the opening beat, captured config afterwards.
    always_comb begin
        if (first_beat) begin
            val_eff    = match_val;
            mask_eff   = match_mask;
            type_eff   = cmp_type;
            len_eff    = (pat_len > 5'(PAT_LEN)) ? 5'(PAT_LEN) : pat_len;
            anchor_eff = anchor;
        end else begin
            val_eff    = cfg_val_q;
            mask_eff   = cfg_mask_q;
            type_eff   = cfg_type_q;
            len_eff    = cfg_len_q;
            anchor_eff = cfg_anchor_q;
        end
    end

    // Lay history and the current beat out as one contiguous byte sequence.
    always_comb begin
        for (int p = 0; p < HIST_N; p++) begin
            seq[p] = first_beat ? 8'h00 : hist_q[p];
        end
        for (int i = 0; i < N_LANES; i++) begin
            seq[HIST_N + i] = char_in[8*i +: 8];
        end
    end

    // Evaluate the window ending on each valid lane. Pattern byte k sits
    // d = len-1-k bytes before the window end.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        hits = '0;
        k    = 0;
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_vld[i] && (len_eff != 5'd0)
                && (off_base + OW'(i + 1) >= OW'(len_eff))
                && (!anchor_eff || (off_base + OW'(i + 1) == OW'(len_eff)))) begin
                hits[i] = 1'b1;
                for (int d = 0; d < PAT_LEN; d++) begin
                    if (d < int'(len_eff)) begin
                        k = int'(len_eff) - 1 - d;
                        if (!byte_cmp(seq[HIST_N + i - d], val_eff[8*k +: 8],
                                      mask_eff[8*k +: 8], type_eff[2*k +: 2])) begin
                            hits[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Record offset of the lowest hitting lane, saturated.
    always_comb begin
        first_off = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                first_off = sat_off(off_base + OW'(i));
            end
        end
    end

    // Keep the newest HIST_N valid bytes. Valid lanes are contiguous from
    // lane 0, so the window simply slides by the valid-lane count.
    always_comb begin
        for (int j = 0; j < HIST_N; j++) begin
            hist_next[j] = seq[n_vld + j];
        end
    end

    // Record FSM, config capture, history, offset and first-hit tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hist_q        <= '0;
            off_q         <= '0;
            cfg_val_q     <= '0;
            cfg_mask_q    <= '0;
            cfg_type_q    <= '0;
            cfg_len_q     <= '0;
            cfg_anchor_q  <= 1'b0;
            hit_vec       <= '0;
            first_hit_vld <= 1'b0;
            first_hit_off <= '0;
            rec_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values regardless of statement order.
            rec_done <= char_valid & char_last;
            hit_vec  <= char_valid ? hits : '0;
            if (char_valid) begin
                if (first_beat) begin
                    cfg_val_q    <= match_val;
                    cfg_mask_q   <= match_mask;
                    cfg_type_q   <= cmp_type;
                    cfg_len_q    <= len_eff;
                    cfg_anchor_q <= anchor;
                end
                off_q  <= off_next;
                hist_q <= char_last ? '0 : hist_next;
                if (!found_before && (|hits)) begin
                    first_hit_vld <= 1'b1;
                    first_hit_off <= first_off;
                end else if (first_beat) begin
                    first_hit_vld <= 1'b0;
                    first_hit_off <= '0;
                end
                if (char_last) begin
                    state_q <= ST_IDLE;
                end else if (found_before || (|hits)) begin
                    state_q <= ST_FOUND;
                end else begin
                    state_q <= ST_SCAN;
                end
            end
        end
    end

`ifdef CR_PREFIX_FE_SEQ_CMP_CNT_EN
    localparam int CW = CNT_W + 9;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CW-1:0]    cnt_sum;

    assign cnt_sum = (first_beat ? CW'(0) : CW'(cnt_q)) + CW'($countones(hits));

    // Saturating per-record hit counter, restarted on each record's first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (char_valid) begin
            cnt_q <= (cnt_sum > CW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
